// File: rtl/sqrt_pkg.sv
// Shared definitions for the integer square-root sequencer and the AU it drives.
package sqrt_pkg;

    // Datapath widths. The radicand stays at 7 bits so that every AU
    // difference fits in signed 8-bit and bit 7 acts as an exact borrow flag.
    localparam int RAD_W  = 7;
    localparam int ROOT_W = 4;
    localparam int REM_W  = 5;
    localparam int AU_W   = 8;

    // AU operation selects
    localparam logic [1:0] AU_ADD = 2'b00;
    localparam logic [1:0] AU_SUB = 2'b10;
    localparam logic [1:0] AU_MAX = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Odd number 2*root+1, zero-extended to the AU operand width
    function automatic logic [AU_W-1:0] odd_of(input logic [ROOT_W-1:0] root);
        return {{(AU_W-ROOT_W-1){1'b0}}, root, 1'b1};
    endfunction

endpackage

// File: rtl/sqrt_seq_ctrl.sv
// Integer square root of a 7-bit radicand by odd-number subtraction.
// Feeds operands to a shared 1-cycle-latency AU and consumes its result:
// each iteration is an ISSUE cycle (register operands) followed by an EVAL
// cycle (sample the difference). A borrow on the difference ends the run.
module sqrt_seq_ctrl
    import sqrt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RAD_W-1:0]  radicand,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROOT_W-1:0] root_out,
    output logic [REM_W-1:0]  rem_out,
    output logic [AU_W-1:0]   au_a,
    output logic [AU_W-1:0]   au_b,
    output logic [1:0]        au_sel,
    input  logic [AU_W-1:0]   au_out
);

    state_t            state;
    logic [RAD_W-1:0]  rem;
    logic [ROOT_W-1:0] root;

    // Borrow from the AU difference: set when the odd number exceeded rem
    logic borrow;
    assign borrow = au_out[AU_W-1];

    // Controller FSM with registered handshake, AU and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register, including the working rem/root, is reset
            // so an aborted computation leaves nothing behind for the next one.
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            root_out  <= '0;
            rem_out   <= '0;
            au_a      <= '0;
            au_b      <= '0;
            au_sel    <= AU_SUB;
            rem       <= '0;
            root      <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge values of rem/root regardless of statement order.
            au_sel <= AU_SUB;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem      <= radicand;
                        root     <= '0;
                        in_ready <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    au_a  <= {{(AU_W-RAD_W){1'b0}}, rem};
                    au_b  <= odd_of(root);
                    state <= EVAL;
                end
                EVAL: begin
                    if (!borrow) begin
                        // Odd number fitted: keep the difference, grow the root
                        rem   <= au_out[RAD_W-1:0];
                        root  <= root + 1'b1;
                        state <= ISSUE;
                    end else begin
                        // Remainder never exceeds 2*root, so REM_W bits suffice
                        root_out  <= root;
                        rem_out   <= rem[REM_W-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
